mux_serializer_8: RTL and testbench

//  Upstream sequencer for the 8-to-1 mux datapath. Accepts an 8-bit word over a

---
 rtl/mux_serializer_8_if.sv | 30 +++
 rtl/mux_serializer_8.sv | 153 +++++++++++++++
 tb/tb_mux_serializer_8.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mux_serializer_8_if.sv
// Handshake and serial-stream bundle for mux_serializer_8.
//   a         : parallel data word (upstream -> serializer)
//   in_valid  : a is valid (upstream -> serializer)
//   in_ready  : serializer can accept a word
//   sel       : index of the bit currently on y
//   y         : serial data bit
//   y_valid   : y carries a valid bit
//   last      : y carries the final bit of the word
//   busy      : a word is being serialized
// master = upstream word source, slave = the serializer itself.
interface mux_serializer_8_if;
  logic [7:0] a;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;
  logic       last;
  logic       busy;

  modport master (
    output a, in_valid,
    input  in_ready, sel, y, y_valid, last, busy
  );

  modport slave (
    input  a, in_valid,
    output in_ready, sel, y, y_valid, last, busy
  );
endinterface

// File: rtl/mux_serializer_8.sv
// Sequencer feeding an 8-to-1 mux datapath: latches an 8-bit word on a valid/ready
// handshake and walks a 3-bit select through all 8 positions, holding each bit on y
// for BIT_CYC clocks. All outputs are registered.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mux_serializer_8_if.slave (a, in_valid in; in_ready, sel, y, y_valid,
//          last, busy out)
// Parameters:
//   BIT_CYC   : clocks per bit (>= 1)
//   MSB_FIRST : 0 -> sel counts 0..7, 1 -> sel counts 7..0
// Optional feature: define MUX_SER_PARITY_EN to append an even-parity bit after the
// eighth data bit (last then marks the parity bit).
module mux_serializer_8 #(
  parameter int unsigned BIT_CYC   = 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  mux_serializer_8_if.slave bus
);

  localparam int unsigned CntW     = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYC - 1);
  localparam logic [2:0] SelFirst  = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] SelLast   = MSB_FIRST ? 3'd0 : 3'd7;

`ifdef MUX_SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d, sel_nxt;
  logic [7:0]      data_q, data_d;
  logic            y_q, y_d;
  logic            y_valid_q, y_valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= SelFirst;
      data_q     <= '0;
      y_q        <= 1'b0;
      y_valid_q  <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    data_d     = data_q;
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    in_ready_d = in_ready_q;
    sel_nxt    = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);

    unique case (state_q)
      StIdle: begin
        // in_ready is always high in idle, so in_valid alone accepts.
        if (bus.in_valid) begin
          state_d    = StShift;
          data_d     = bus.a;
          cnt_d      = '0;
          sel_d      = SelFirst;
          y_d        = bus.a[SelFirst];
          y_valid_d  = 1'b1;
          last_d     = 1'b0;
          busy_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end
      StShift: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (sel_q != SelLast) begin
            sel_d = sel_nxt;
            y_d   = data_q[sel_nxt];
`ifdef MUX_SER_PARITY_EN
            last_d = 1'b0;
`else
            last_d = (sel_nxt == SelLast);
`endif
          end else begin
`ifdef MUX_SER_PARITY_EN
            // sel stays on the final data index during the parity period.
            state_d = StPar;
            y_d     = ^data_q;
            last_d  = 1'b1;
`else
            state_d    = StIdle;
            sel_d      = SelFirst;
            y_d        = 1'b0;
            y_valid_d  = 1'b0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            in_ready_d = 1'b1;
`endif
          end
        end
      end
`ifdef MUX_SER_PARITY_EN
      StPar: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d      = '0;
          state_d    = StIdle;
          sel_d      = SelFirst;
          y_d        = 1'b0;
          y_valid_d  = 1'b0;
          last_d     = 1'b0;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready = in_ready_q;
  assign bus.sel      = sel_q;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.last     = last_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mux_serializer_8.sv
// Self-checking bench for mux_serializer_8. Two instances: LSB-first with one clock
// per bit, and MSB-first with three clocks per bit. Expected streams come from a
// word-level model: ordered bit list, each bit repeated BIT_CYC times, then idle.
module tb_mux_serializer_8;

`ifdef MUX_SER_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_serializer_8_if bus0 ();
  mux_serializer_8_if bus1 ();

  mux_serializer_8 #(.BIT_CYC(1), .MSB_FIRST(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  mux_serializer_8 #(.BIT_CYC(3), .MSB_FIRST(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  function automatic int bit_cyc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit msb(input int d);
    return d == 1;
  endfunction

  // {y_valid, y, sel[2:0], last, busy, in_ready}
  function automatic logic [7:0] obs(input int d);
    if (d == 0) return {bus0.y_valid, bus0.y, bus0.sel, bus0.last, bus0.busy, bus0.in_ready};
    return {bus1.y_valid, bus1.y, bus1.sel, bus1.last, bus1.busy, bus1.in_ready};
  endfunction

  function automatic logic [7:0] idle_exp(input int d);
    return {1'b0, 1'b0, (msb(d) ? 3'd7 : 3'd0), 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] w);
    if (d == 0) begin
      bus0.in_valid = v;
      bus0.a        = w;
    end else begin
      bus1.in_valid = v;
      bus1.a        = w;
    end
  endtask

  // Entered #1 after the accept edge; checks every bit period then the idle return.
  task automatic check_stream(input int d, input logic [7:0] w, input string name);
    logic [7:0] exp;
    for (int i = 0; i < 8 + Par; i++) begin
      int   idx;
      logic b;
      logic l;
      if (i < 8) begin
        idx = msb(d) ? 7 - i : i;
        b   = w[idx];
        l   = (i == 7) && (Par == 0);
      end else begin
        idx = msb(d) ? 0 : 7;
        b   = ^w;
        l   = 1'b1;
      end
      for (int c = 0; c < bit_cyc(d); c++) begin
        exp = {1'b1, b, 3'(idx), l, 1'b1, 1'b0};
        checks++;
        if (obs(d) !== exp) begin
          errors++;
          $display("FAIL %s dut%0d word=%h bit%0d cyc%0d got=%b want=%b",
                   name, d, w, i, c, obs(d), exp);
        end
        @(posedge clk); #1;
      end
    end
    exp = idle_exp(d);
    checks++;
    if (obs(d) !== exp) begin
      errors++;
      $display("FAIL %s_end dut%0d word=%h got=%b want=%b", name, d, w, obs(d), exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] w, input string name);
    drive(d, 1'b1, w);
    @(posedge clk); #1;
    drive(d, 1'b0, 8'($urandom));
    check_stream(d, w, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== idle_exp(d)) begin
        errors++;
        $display("FAIL reset dut%0d got=%b want=%b", d, obs(d), idle_exp(d));
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lsb_basic();
    send(0, 8'b1010_1010, "lsb_aa");
  endtask

  task automatic test_msb_slow();
    send(1, 8'hC3, "msb_c3");
  endtask

  // in_valid held with a changed mid-word; second word must start one edge after
  // in_ready rises.
  task automatic test_back_to_back();
    drive(0, 1'b1, 8'h3C);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'hFF);
    check_stream(0, 8'h3C, "b2b_first");
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00);
    check_stream(0, 8'hFF, "b2b_second");
  endtask

  task automatic test_reset_midword();
    drive(0, 1'b1, 8'h5A);
    drive(1, 1'b1, 8'hA5);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== idle_exp(d)) begin
        errors++;
        $display("FAIL rst_mid dut%0d got=%b want=%b", d, obs(d), idle_exp(d));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h01, "after_rst");
    send(1, 8'h01, "after_rst_msb");
  endtask

  task automatic test_parity_words();
    send(0, 8'b1010_1010, "par_aa");
    send(0, 8'h01, "par_01");
    send(1, 8'h07, "par_07_msb");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int         d;
      logic [7:0] w;
      d = int'($urandom_range(0, 1));
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(d, w, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_slow();
    test_back_to_back();
    test_reset_midword();
    test_parity_words();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
